// File: rtl/nibble_accumulator_pkg.sv
// Shared types and helpers for the nibble accumulator slice.
// Consumed by nibble_negext and nibble_accumulator.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [NIBBLE_W:0] sext5(input logic [NIBBLE_W-1:0] d);
        return {d[NIBBLE_W-1], d};
    endfunction

endpackage

// File: rtl/nibble_accumulator_negext.sv
// Turns a signed nibble into a sign-extended (ACC_W+1)-bit operand, optionally negated.
// Negation is done at 5 bits so that -(-8) yields +8 without wrapping.
module nibble_negext
    import nibble_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [NIBBLE_W-1:0] in_data,
    input  logic                sub,
    output logic [ACC_W:0]      operand
);

    logic [NIBBLE_W:0] v5;
    logic [NIBBLE_W:0] n5;

    always_comb begin
        v5      = sext5(in_data);
        n5      = sub ? (~v5 + 5'd1) : v5;
        operand = {{(ACC_W - NIBBLE_W){n5[NIBBLE_W]}}, n5};
    end

endmodule

// File: rtl/nibble_accumulator.sv
// Block accumulator of signed nibbles with add/subtract per sample and sticky overflow.
// Define NIBBLE_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module nibble_accumulator
    import nibble_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int BLOCK_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_data,
    output logic [ACC_W-1:0]    acc_out,
    output logic                out_valid,
    output logic                ovf,
    output logic                busy
);

    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
`ifdef NIBBLE_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic             accept;

    nibble_negext #(.ACC_W(ACC_W)) u_negext (
        .in_data (in_data),
        .sub     (sub),
        .operand (operand)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // Overflow when the extra top bit disagrees with the ACC_W-bit sign.
    always_comb begin
        sum     = {acc_out[ACC_W-1], acc_out} + operand;
        sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef NIBBLE_ACC_SATURATE_EN
        if (sum_ovf)
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            acc_nxt = sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            acc_out <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCUM;
                        count   <= '0;
                        acc_out <= '0;
                        ovf     <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_out <= acc_nxt;
                        count   <= count + 1'b1;
                        if (sum_ovf)
                            ovf <= 1'b1;
                        if (count == LAST)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_accumulator.sv
// Scoreboard bench: directed blocks push expected {acc, ovf}; monitors pop on out_valid.
// Overflow expectation follows NIBBLE_ACC_SATURATE_EN.
module tb_nibble_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start20 = 1'b0;
    logic       sub = 1'b0, in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;

    logic       rdy4, ov4, ovf4, busy4;
    logic [7:0] acc4;
    logic       rdy20, ov20, ovf20, busy20;
    logic [7:0] acc20;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [7:0] acc; logic ovf; } exp_t;
    exp_t q4[$];
    exp_t q20[$];

    always #5 clk = ~clk;

    nibble_accumulator #(.ACC_W(8), .BLOCK_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .in_valid(in_valid),
        .in_ready(rdy4), .in_data(in_data), .acc_out(acc4), .out_valid(ov4),
        .ovf(ovf4), .busy(busy4)
    );

    nibble_accumulator #(.ACC_W(8), .BLOCK_LEN(20)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .start(start20), .sub(sub), .in_valid(in_valid),
        .in_ready(rdy20), .in_data(in_data), .acc_out(acc20), .out_valid(ov20),
        .ovf(ovf20), .busy(busy20)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitors: pop expected result on each out_valid, and insist on single-cycle pulses.
    logic prev4 = 1'b0, prev20 = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ov4) begin
            exp_t e;
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL sb4_spurious: out_valid with acc=%0h, nothing expected", acc4);
            end else begin
                e = q4.pop_front();
                if (acc4 !== e.acc || ovf4 !== e.ovf) begin
                    bad++;
                    $display("FAIL sb4_result: got acc=%0h ovf=%0b want acc=%0h ovf=%0b",
                             acc4, ovf4, e.acc, e.ovf);
                end
            end
            total++;
            if (prev4) begin
                bad++;
                $display("FAIL sb4_pulse: out_valid high 2 cycles, got 1 want 0");
            end
        end
        prev4 = rst_n && ov4;
    end

    always @(negedge clk) begin
        if (rst_n && ov20) begin
            exp_t e;
            total++;
            if (q20.size() == 0) begin
                bad++;
                $display("FAIL sb20_spurious: out_valid with acc=%0h, nothing expected", acc20);
            end else begin
                e = q20.pop_front();
                if (acc20 !== e.acc || ovf20 !== e.ovf) begin
                    bad++;
                    $display("FAIL sb20_result: got acc=%0h ovf=%0b want acc=%0h ovf=%0b",
                             acc20, ovf20, e.acc, e.ovf);
                end
            end
            total++;
            if (prev20) begin
                bad++;
                $display("FAIL sb20_pulse: out_valid high 2 cycles, got 1 want 0");
            end
        end
        prev20 = rst_n && ov20;
    end

    task automatic do_start(input bit sel);
        @(negedge clk);
        if (sel) start20 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start4  = 1'b0;
        start20 = 1'b0;
    endtask

    // Present one sample and hold it until the selected DUT accepts it.
    task automatic send(input bit sel, input logic [3:0] d, input logic s);
        int n = 0;
        @(negedge clk);
        in_data  = d;
        sub      = s;
        in_valid = 1'b1;
        while (!(sel ? rdy20 : rdy4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_acc", acc4, 8'h00);
        chk("rst_flags", {rdy4, ov4, ovf4, busy4}, 4'b0000);
        chk("rst_acc20", acc20, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // start with in_valid high in IDLE: no sample accepted
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd5;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("start_no_accept_acc", acc4, 8'h00);
        chk("start_busy_ready", {busy4, rdy4}, 2'b11);

        // add block 1+2+3+4 = 10
        q4.push_back('{8'h0A, 1'b0});
        send(0, 4'd1, 0); send(0, 4'd2, 0); send(0, 4'd3, 0); send(0, 4'd4, 0);
        @(negedge clk);
        chk("add_latency_ov", ov4, 1'b1);
        chk("add_acc", acc4, 8'h0A);
        @(negedge clk);
        chk("idle_after_done", {busy4, ov4, rdy4}, 3'b000);
        chk("idle_hold_acc", acc4, 8'h0A);

        // negate edge: four -(-8) = +32
        q4.push_back('{8'h20, 1'b0});
        do_start(0);
        repeat (4) send(0, 4'b1000, 1);
        repeat (2) @(negedge clk);

        // mixed with gaps: 7 - (-3) + (-8) - 1 = 1
        q4.push_back('{8'h01, 1'b0});
        do_start(0);
        send(0, 4'd7, 0);
        repeat (3) @(negedge clk);
        chk("gap_hold_acc", acc4, 8'h07);
        chk("gap_busy", {busy4, rdy4}, 2'b11);
        send(0, 4'hD, 1);
        repeat (2) @(negedge clk);
        send(0, 4'h8, 0);
        @(negedge clk);
        chk("gap_partial_acc", acc4, 8'h02);
        send(0, 4'd1, 1);
        repeat (2) @(negedge clk);

        // overflow on the 20-sample instance: 20*7 = 140
`ifdef NIBBLE_ACC_SATURATE_EN
        q20.push_back('{8'h7F, 1'b1});
`else
        q20.push_back('{8'h8C, 1'b1});
`endif
        do_start(1);
        repeat (20) send(1, 4'd7, 0);
        repeat (3) @(negedge clk);
        chk("ovf_sticky_idle", ovf20, 1'b1);

        // reset mid-block
        do_start(0);
        send(0, 4'd1, 0); send(0, 4'd1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", acc4, 8'h00);
        chk("midrst_flags", {busy4, rdy4, ov4}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_wait_idle", busy4, 1'b0);
        q4.push_back('{8'h04, 1'b0});
        do_start(0);
        repeat (4) send(0, 4'd1, 0);
        repeat (2) @(negedge clk);

        // start ignored in ACCUM and DONE: 2+3+4+5 = 14
        q4.push_back('{8'h0E, 1'b0});
        do_start(0);
        send(0, 4'd2, 0);
        start4 = 1'b1;
        send(0, 4'd3, 0);
        start4 = 1'b0;
        send(0, 4'd4, 0);
        send(0, 4'd5, 0);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(negedge clk);
        chk("start_ignored_idle", busy4, 1'b0);
        chk("start_ignored_acc", acc4, 8'h0E);

        // ovf and acc clear only on an IDLE start
        do_start(1);
        @(negedge clk);
        chk("restart_clear", {acc20, ovf20}, 9'h000);

        repeat (2) @(negedge clk);
        total++;
        if (q4.size() != 0 || q20.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending got %0d want 0", q4.size() + q20.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
